// File: rtl/exercise7_mod_updown_counter.sv
// exercise7_mod_updown_counter
//   Modulo up/down counter with synchronous load, a one-cycle boundary pulse
//   (ovf) and a combinational at_limit flag.
//   SATURATE=0 wraps at the bounds; SATURATE=1 holds at the bounds.
//   Optional feature macro: MOD_COUNTER_STICKY_OVF_EN
//     defined   -> ovf_sticky latches every boundary event until load or rst
//     undefined -> ovf_sticky is tied to 0 and no sticky flop exists
//   Edge priority: rst > load > en > hold.
module exercise7_mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             ovf,
  output logic             ovf_sticky
);

  // Reject illegal parameterisations at elaboration time. WIDTH is capped so
  // that 2**WIDTH-1 is representable in the int used for MAX_VAL.
  generate
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("exercise7_mod_updown_counter: WIDTH=%0d out of range 1..31", WIDTH);
    end
    if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH)-1) begin : g_bad_max
      $error("exercise7_mod_updown_counter: MAX_VAL=%0d out of range 1..%0d",
             MAX_VAL, (2**WIDTH)-1);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  // Bound detection shared by the next-state logic and at_limit.
  assign at_max  = (count_q == MAX_V);
  assign at_zero = (count_q == '0);

  // Next-state: load (clamped to MAX_VAL) beats counting; boundary steps
  // either wrap or hold, and raise ovf for exactly the cycle they happen.
  // The +1 is only taken below MAX_VAL, so it can never overflow WIDTH bits.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_V : '0;
        end else begin
          count_d = count_q + ONE_V;
        end
      end else begin
        if (at_zero) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? '0 : MAX_V;
        end else begin
          count_d = count_q - ONE_V;
        end
      end
    end
  end

  // Counter and pulse registers; reset clears both regardless of other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign ovf      = ovf_q;
  assign at_limit = (up && at_max) || (!up && at_zero);

`ifdef MOD_COUNTER_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Sticky flag: load clears it (ovf_d is never set on a load edge, so a
  // load wins over a same-edge boundary event); otherwise any event sets it.
  always_comb begin
    sticky_d = sticky_q;
    if (load) begin
      sticky_d = 1'b0;
    end else if (ovf_d) begin
      sticky_d = 1'b1;
    end
  end

  // Sticky register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_exercise7_mod_updown_counter.sv
// Directed bench for exercise7_mod_updown_counter (WIDTH=8, MAX_VAL=9).
// Instance u_wrap uses SATURATE=0, instance u_sat uses SATURATE=1.
module tb_exercise7_mod_updown_counter;

`ifdef MOD_COUNTER_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // wrap-mode instance signals
  logic       w_rst, w_en, w_up, w_load;
  logic [7:0] w_load_val, w_count;
  logic       w_at_limit, w_ovf, w_sticky;
  // saturate-mode instance signals
  logic       s_rst, s_en, s_up, s_load;
  logic [7:0] s_load_val, s_count;
  logic       s_at_limit, s_ovf, s_sticky;

  int n_total = 0;
  int n_bad   = 0;

  exercise7_mod_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(w_rst), .en(w_en), .up(w_up), .load(w_load),
    .load_val(w_load_val), .count(w_count), .at_limit(w_at_limit),
    .ovf(w_ovf), .ovf_sticky(w_sticky)
  );

  exercise7_mod_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load),
    .load_val(s_load_val), .count(s_count), .at_limit(s_at_limit),
    .ovf(s_ovf), .ovf_sticky(s_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w_rst = 1'b1; w_en = 1'b1; w_up = 1'b1; w_load = 1'b1; w_load_val = 8'd5;
    s_rst = 1'b1; s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_load_val = 8'd0;
    step();
    // reset state, load/en ignored under reset
    chk("rst_count", w_count, 0);
    chk("rst_ovf", w_ovf, 0);
    chk("rst_sticky", w_sticky, 0);
    chk("rst_at_limit", w_at_limit, 0);
    chk("sat_rst_count", s_count, 0);

    // wrap up for 12 cycles: 1..9,0,1,2
    w_rst = 1'b0; w_load = 1'b0; w_en = 1'b1; w_up = 1'b1;
    s_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("up_count[%0d]", i), w_count, (i + 1) % 10);
      chk($sformatf("up_ovf[%0d]", i), w_ovf, ((i + 1) % 10) == 0);
      chk($sformatf("up_at_limit[%0d]", i), w_at_limit, ((i + 1) % 10) == 9);
    end
    chk("up_sticky", w_sticky, STICKY);

    // wrap down from 0
    w_rst = 1'b1; step();
    chk("rst2_sticky", w_sticky, 0);
    w_rst = 1'b0; w_en = 1'b0; w_up = 1'b0; #1;
    chk("dn_at_limit0", w_at_limit, 1);
    w_en = 1'b1;
    step();
    chk("dn_count0", w_count, 9);
    chk("dn_ovf0", w_ovf, 1);
    step();
    chk("dn_count1", w_count, 8);
    chk("dn_ovf1", w_ovf, 0);
    chk("dn_at_limit1", w_at_limit, 0);

    // load clamp and load beats en
    w_load = 1'b1; w_load_val = 8'd200; w_up = 1'b1;
    step();
    chk("clamp_count", w_count, 9);
    chk("clamp_ovf", w_ovf, 0);
    w_load_val = 8'd3;
    step();
    chk("load3_count", w_count, 3);
    chk("load_clr_sticky", w_sticky, 0);

    // hold
    w_load = 1'b0; w_en = 1'b0;
    step();
    chk("hold_count", w_count, 3);
    chk("hold_ovf", w_ovf, 0);

    // reset beats load/en
    w_load = 1'b1; w_load_val = 8'd5; step();
    chk("pre_rst_count", w_count, 5);
    w_rst = 1'b1; w_load = 1'b1; w_load_val = 8'd7; w_en = 1'b1;
    step();
    chk("rstpri_count", w_count, 0);
    chk("rstpri_ovf", w_ovf, 0);
    chk("rstpri_sticky", w_sticky, 0);
    w_rst = 1'b0; w_load = 1'b0; w_en = 1'b0;
    step();
    chk("post_rst_ovf", w_ovf, 0);
    w_en = 1'b1; w_up = 1'b1;
    step();
    chk("first_step", w_count, 1);

    // sticky behaviour
    w_load = 1'b1; w_load_val = 8'd9; w_en = 1'b0; step();
    w_load = 1'b0; w_en = 1'b1; w_up = 1'b1;
    step();
    chk("stk_count", w_count, 0);
    chk("stk_ovf", w_ovf, 1);
    chk("stk_set", w_sticky, STICKY);
    w_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stk_hold[%0d]", i), w_sticky, STICKY);
      chk($sformatf("stk_ovf_low[%0d]", i), w_ovf, 0);
    end
    w_load = 1'b1; w_load_val = 8'd0;
    step();
    chk("stk_clr", w_sticky, 0);
    chk("stk_clr_count", w_count, 0);

    // load at MAX with en/up: load wins over the boundary event
    w_load_val = 8'd9; step();
    w_en = 1'b1; w_up = 1'b1;
    step();
    chk("ldpri_count", w_count, 9);
    chk("ldpri_ovf", w_ovf, 0);
    chk("ldpri_sticky", w_sticky, 0);
    w_load = 1'b0; w_en = 1'b0;

    // saturate up: load 8, then 3 up steps -> 9,9,9 with ovf 0,1,1
    s_load = 1'b1; s_load_val = 8'd8; step();
    chk("sat_load", s_count, 8);
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_up_count[%0d]", i), s_count, 9);
      chk($sformatf("sat_up_ovf[%0d]", i), s_ovf, i != 0);
    end
    chk("sat_at_limit_up", s_at_limit, 1);
    chk("sat_sticky", s_sticky, STICKY);

    // saturate down: load 1, then 0,0 with ovf 0,1
    s_load = 1'b1; s_load_val = 8'd1; s_en = 1'b0; step();
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
    step();
    chk("sat_dn_count0", s_count, 0);
    chk("sat_dn_ovf0", s_ovf, 0);
    step();
    chk("sat_dn_count1", s_count, 0);
    chk("sat_dn_ovf1", s_ovf, 1);
    chk("sat_at_limit_dn", s_at_limit, 1);
    s_en = 1'b0;
    step();
    chk("sat_idle_ovf", s_ovf, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
